// File: rtl/mem_ctrl.sv
// mem_ctrl: single-master SRAM (base/ext) and UART bus controller with sub-word lanes.
// Define MEM_CTRL_UART_EN to enable the UART region; otherwise UART accesses complete as errors.
module mem_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter bit BIG_ENDIAN  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy,
    inout  wire  [31:0] base_ram_data,
    output logic [19:0] base_ram_addr,
    output logic [3:0]  base_ram_be_n,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n,
    inout  wire  [31:0] ext_ram_data,
    output logic [19:0] ext_ram_addr,
    output logic [3:0]  ext_ram_be_n,
    output logic        ext_ram_ce_n,
    output logic        ext_ram_oe_n,
    output logic        ext_ram_we_n,
    output logic        uart_rdn,
    output logic        uart_wrn,
    input  logic        uart_dataready,
    input  logic        uart_tbre,
    input  logic        uart_tsre
);
    localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, DONE = 2'd3;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state, size_r, span, lo_lane;
    logic [3:0]  cnt, lanes;
    logic        we_r, sx_r, bad_r, bad, uart_err, misalign;
    logic        is_uart, is_ext, is_base, active, strobe, base_drive;
    logic [31:0] addr_r, wdata_r, wlanes, src, sh, sub, rd_next;

    assign misalign = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00) || size == 2'b11;
    assign bad      = misalign || uart_err;

    assign is_uart = addr_r[29];
    assign is_ext  = !is_uart && addr_r[22];
    assign is_base = !is_uart && !addr_r[22];
    assign active  = state != IDLE && !bad_r;
    assign strobe  = state == ACCESS && !bad_r;

    // lo_lane is the least significant byte lane touched by the access
    assign span    = size_r == 2'b00 ? 2'd0 : size_r == 2'b01 ? 2'd1 : 2'd3;
    assign lo_lane = BIG_ENDIAN ? 2'd3 - addr_r[1:0] - span : addr_r[1:0];
    assign lanes   = (size_r == 2'b00 ? 4'b0001 : size_r == 2'b01 ? 4'b0011 : 4'b1111) << lo_lane;
    assign wlanes  = size_r == 2'b00 ? {4{wdata_r[7:0]}} : size_r == 2'b01 ? {2{wdata_r[15:0]}} : wdata_r;

    assign base_ram_addr = addr_r[21:2];
    assign ext_ram_addr  = addr_r[21:2];
    assign base_ram_ce_n = !(active && is_base);
    assign ext_ram_ce_n  = !(active && is_ext);
    assign base_ram_be_n = active && is_base ? ~lanes : 4'hF;
    assign ext_ram_be_n  = active && is_ext ? ~lanes : 4'hF;
    assign base_ram_oe_n = !(strobe && is_base && !we_r);
    assign base_ram_we_n = !(strobe && is_base && we_r);
    assign ext_ram_oe_n  = !(strobe && is_ext && !we_r);
    assign ext_ram_we_n  = !(strobe && is_ext && we_r);

    // UART data shares the base bus low byte
    assign base_drive    = active && we_r && !is_ext;
    assign base_ram_data = base_drive ? (is_uart ? {24'b0, wdata_r[7:0]} : wlanes) : 32'bz;
    assign ext_ram_data  = active && we_r && is_ext ? wlanes : 32'bz;

    assign src = is_ext ? ext_ram_data : base_ram_data;
    assign sh  = src >> {lo_lane, 3'b000};
    assign sub = size_r == 2'b00 ? {{24{sx_r & sh[7]}}, sh[7:0]} :
                 size_r == 2'b01 ? {{16{sx_r & sh[15]}}, sh[15:0]} : sh;

`ifdef MEM_CTRL_UART_EN
    assign uart_err = addr[29] && addr[2] && we;
    assign uart_rdn = !(strobe && is_uart && !addr_r[2] && !we_r);
    assign uart_wrn = !(strobe && is_uart && !addr_r[2] && we_r);
    assign rd_next  = !is_uart ? sub : addr_r[2] ? {30'b0, uart_dataready, uart_tbre} : {24'b0, base_ram_data[7:0]};
    logic unused;
    assign unused = &{1'b0, uart_tsre, addr_r[31:30], addr_r[28:23]};
`else
    assign uart_err = addr[29];
    assign uart_rdn = 1'b1;
    assign uart_wrn = 1'b1;
    assign rd_next  = sub;
    logic unused;
    assign unused = &{1'b0, uart_dataready, uart_tbre, uart_tsre, addr_r[31:30], addr_r[28:23]};
`endif

    assign ack  = state == DONE;
    assign err  = state == DONE && bad_r;
    assign busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata   <= 32'd0;
            we_r    <= 1'b0;
            sx_r    <= 1'b0;
            bad_r   <= 1'b0;
            size_r  <= 2'b00;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
        end else begin
            unique case (state)
                IDLE: if (req) begin
                    we_r    <= we;
                    addr_r  <= addr;
                    wdata_r <= wdata;
                    size_r  <= size;
                    sx_r    <= sign_ext;
                    bad_r   <= bad;
                    state   <= bad ? DONE : SETUP;
                end
                SETUP: begin
                    cnt   <= CNT_LOAD;
                    state <= ACCESS;
                end
                ACCESS: if (cnt == 4'd0) begin
                    state <= DONE;
                    if (!we_r) rdata <= rd_next;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized scoreboard bench for mem_ctrl against a byte-addressed reference memory.
module tb_mem_ctrl;
    localparam int W  = 2;
    localparam bit BE = 1;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 0, rst = 1, req = 0, we = 0, sign_ext = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [1:0]  size = 0;
    logic        uart_dataready = 0, uart_tbre = 0, uart_tsre = 1;
    logic [31:0] rdata;
    logic        ack, err, busy;
    wire  [31:0] base_ram_data, ext_ram_data;
    logic [19:0] base_ram_addr, ext_ram_addr;
    logic [3:0]  base_ram_be_n, ext_ram_be_n;
    logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
    logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;
    logic        uart_rdn, uart_wrn;

    mem_ctrl #(.WAIT_CYCLES(W), .BIG_ENDIAN(BE)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .size(size),
        .sign_ext(sign_ext), .rdata(rdata), .ack(ack), .err(err), .busy(busy),
        .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr), .base_ram_be_n(base_ram_be_n),
        .base_ram_ce_n(base_ram_ce_n), .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
        .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr), .ext_ram_be_n(ext_ram_be_n),
        .ext_ram_ce_n(ext_ram_ce_n), .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n),
        .uart_rdn(uart_rdn), .uart_wrn(uart_wrn), .uart_dataready(uart_dataready),
        .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    logic rst_q = 1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // physical SRAM chips, lane-organised words
    logic [31:0] phys [2][16];
    logic [7:0]  uart_rx = 0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] ben);
        for (int k = 0; k < 4; k++) if (!ben[k]) o[8*k+:8] = n[8*k+:8];
        return o;
    endfunction

    always @(posedge clk) begin
        if (!base_ram_ce_n && !base_ram_we_n)
            phys[0][base_ram_addr[3:0]] <= merge(phys[0][base_ram_addr[3:0]], base_ram_data, base_ram_be_n);
        if (!ext_ram_ce_n && !ext_ram_we_n)
            phys[1][ext_ram_addr[3:0]] <= merge(phys[1][ext_ram_addr[3:0]], ext_ram_data, ext_ram_be_n);
    end

    assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n) ? phys[0][base_ram_addr[3:0]] :
                           !uart_rdn ? {24'hA5C3E1, uart_rx} : 32'bz;
    assign ext_ram_data  = (!ext_ram_ce_n && !ext_ram_oe_n) ? phys[1][ext_ram_addr[3:0]] : 32'bz;

    // reference: byte-addressed memory per region, plus expected results
    logic [7:0]  refm [2][64];
    logic [31:0] last_rd = 0;
    logic [7:0]  uart_txq [$];
    exp_t        sbq [$];
    int          errors = 0, checks = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, required %h", n, cyc, a, e);
        end
    endtask

    task automatic model(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                         input logic sx, output logic e, output logic [31:0] rd);
        int n, r, o;
        logic [31:0] v;
        n = sz == 0 ? 1 : sz == 1 ? 2 : 4;
        e = sz == 3 || (int'(a[1:0]) % n) != 0;
`ifdef MEM_CTRL_UART_EN
        e = e || (a[29] && a[2] && w);
`else
        e = e || a[29];
`endif
        r = int'(a[22]);
        o = int'(a[5:0]);
        rd = last_rd;
        if (!e && !w) begin
            if (a[29]) rd = a[2] ? {30'b0, uart_dataready, uart_tbre} : {24'b0, uart_rx};
            else begin
                v = 0;
                for (int i = 0; i < n; i++) v = BE ? (v << 8) | 32'(refm[r][o+i]) : v | (32'(refm[r][o+i]) << (8*i));
                rd = n == 1 ? ((sx && v[7]) ? v | 32'hFFFF_FF00 : v) :
                     n == 2 ? ((sx && v[15]) ? v | 32'hFFFF_0000 : v) : v;
            end
            last_rd = rd;
        end
        if (!e && w) begin
            if (a[29]) uart_txq.push_back(wd[7:0]);
            else for (int i = 0; i < n; i++) refm[r][o+i] = BE ? wd[8*(n-1-i)+:8] : wd[8*i+:8];
        end
    endtask

    logic [19:0] s_ba;
    logic [3:0]  s_bbe, s_ebe;
    logic [7:0]  s_ctl;
    logic        s_ack, s_err;
    logic        u_dr = 0, u_tb = 0;
    logic [7:0]  u_rx = 0;

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                          input logic sx, input logic hold, output int acc);
        int t;
        logic e;
        logic [31:0] rd;
        exp_t x;
        t = 0;
        @(negedge clk);
        while (busy) begin
            t++;
            if (t > 50) begin
                $display("FAIL idle_timeout at cycle %0d: busy stuck at 1, required 0", cyc);
                errors++;
                $fatal(1, "bench stopped");
            end
            @(negedge clk);
        end
        uart_rx = u_rx; uart_dataready = u_dr; uart_tbre = u_tb;
        req = 1; we = w; addr = a; wdata = wd; size = sz; sign_ext = sx;
        @(posedge clk);
        #1;
        acc = cyc;
        model(w, a, wd, sz, sx, e, rd);
        x.cyc = e ? acc : acc + 1 + W;
        x.err = e;
        x.rd  = rd;
        sbq.push_back(x);
        req = hold ? 1'b1 : 1'($urandom);
        we = 1'($urandom); addr = $urandom; wdata = $urandom; size = 2'($urandom); sign_ext = 1'($urandom);
        @(negedge clk);
        s_ba = base_ram_addr; s_bbe = base_ram_be_n; s_ebe = ext_ram_be_n; s_ack = ack; s_err = err;
        s_ctl = {base_ram_ce_n, base_ram_oe_n, base_ram_we_n, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n, uart_rdn, uart_wrn};
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", sbq.size(), 0);
        @(negedge clk);
    endtask

    int   run [4] = '{0, 0, 0, 0};
    exp_t mx;
    always @(negedge clk) begin
        logic [3:0] sl;
        sl = {!uart_wrn, !uart_rdn, !ext_ram_oe_n || !ext_ram_we_n, !base_ram_oe_n || !base_ram_we_n};
        if (rst_q) begin
            for (int k = 0; k < 4; k++) run[k] = 0;
        end else begin
            chk("ce_exclusive", 32'(!base_ram_ce_n && !ext_ram_ce_n), 0);
            chk("oe_we_exclusive", 32'((!base_ram_oe_n && !base_ram_we_n) || (!ext_ram_oe_n && !ext_ram_we_n)), 0);
            chk("uart_vs_sram", 32'((!uart_rdn || !uart_wrn) && (!base_ram_ce_n || !ext_ram_ce_n)), 0);
            chk("err_without_ack", 32'(err && !ack), 0);
            if (ack) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack at cycle %0d: got ack=1, required ack=0", cyc);
                end else begin
                    mx = sbq.pop_front();
                    chk("ack_cycle", cyc, mx.cyc);
                    chk("err", 32'(err), 32'(mx.err));
                    chk("rdata", rdata, mx.rd);
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (sl[k]) begin
                    if (k == 3 && run[3] == 0) begin
                        if (uart_txq.size() == 0) chk("uart_tx_unexpected", 32'(uart_wrn), 1);
                        else chk("uart_tx_data", 32'(base_ram_data[7:0]), 32'(uart_txq.pop_front()));
                    end
                    run[k]++;
                end else if (run[k] > 0) begin
                    chk("strobe_width", run[k], W);
                    run[k] = 0;
                end
            end
        end
    end

    int acc, accs [5];
    initial begin
        for (int r = 0; r < 2; r++) for (int i = 0; i < 16; i++) phys[r][i] = 0;
        for (int r = 0; r < 2; r++) for (int i = 0; i < 64; i++) refm[r][i] = 0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ack", 32'({ack, err}), 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_strobes", 32'({base_ram_ce_n, base_ram_oe_n, base_ram_we_n, ext_ram_ce_n,
                                  ext_ram_oe_n, ext_ram_we_n, uart_rdn, uart_wrn}), 32'hFF);
        chk("reset_be", 32'({base_ram_be_n, ext_ram_be_n}), 32'hFF);
        rst = 0;

        access(1, 32'h8000_0010, 32'h1234_5678, 2'b10, 0, 0, acc);
        req = 0;
        chk("word_wr_addr", 32'(s_ba), 32'h4);
        chk("word_wr_be", 32'(s_bbe), 0);
        chk("word_wr_setup_ctl", 32'(s_ctl), 32'b0111_1111);

        access(1, 32'h8040_0000, 32'h0000_0080, 2'b10, 0, 0, acc);
        access(0, 32'h8040_0003, 32'h0, 2'b00, 1, 0, acc);
        req = 0;
        chk("byte_rd_be", 32'(s_ebe), 32'hE);
        drain();
        chk("byte_rd_sext", rdata, 32'hFFFF_FF80);

        access(0, 32'h8000_0001, 32'h0, 2'b01, 0, 0, acc);
        req = 0;
        chk("misalign_ack", 32'({s_ack, s_err}), 32'h3);
        chk("misalign_ctl", 32'(s_ctl), 32'hFF);

        u_dr = 1; u_tb = 0;
        access(0, 32'hBFD0_03FC, 32'h0, 2'b10, 0, 0, acc);
        req = 0;
        drain();
`ifdef MEM_CTRL_UART_EN
        chk("uart_status", rdata, 32'h2);
`else
        chk("uart_disabled_err", 32'({s_ack, s_err}), 32'h3);
`endif

        for (int i = 0; i < 5; i++) access(1, 32'h8000_0000 | 32'(i << 2), $urandom, 2'b10, 0, 1, accs[i]);
        req = 0;
        for (int i = 1; i < 5; i++) chk("b2b_period", accs[i] - accs[i-1], W + 3);

        for (int i = 0; i < 300; i++) begin
            logic [1:0]  sz;
            logic [1:0]  off;
            logic [31:0] a;
            int          reg_sel;
            reg_sel = int'($urandom_range(0, 4));
            sz  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            off = 2'($urandom);
            if ($urandom_range(0, 3) != 0) off = off & (sz == 2'b01 ? 2'b10 : sz == 2'b10 ? 2'b00 : 2'b11);
            a = reg_sel == 4 ? (32'hBFD0_03F8 | 32'($urandom_range(0, 1) << 2) | 32'(off)) :
                (32'h8000_0000 | 32'((reg_sel / 2) << 22) | 32'($urandom_range(0, 15) << 2) | 32'(off));
            u_dr = 1'($urandom); u_tb = 1'($urandom); u_rx = 8'($urandom);
            access(1'($urandom), a, $urandom, sz, 1'($urandom), 1'($urandom), acc);
        end
        req = 0;
        drain();

        access(1, 32'h8000_0020, 32'hCAFE_BABE, 2'b10, 0, 0, acc);
        req = 0;
        void'(sbq.pop_back());
        @(negedge clk);
        chk("abort_in_access", 32'(base_ram_we_n), 0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        last_rd = 0;
        chk("abort_we_n", 32'(base_ram_we_n), 1);
        chk("abort_ce_n", 32'(base_ram_ce_n), 1);
        chk("abort_be_n", 32'(base_ram_be_n), 32'hF);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ack", 32'({ack, err}), 0);
        chk("abort_rdata", rdata, 0);
        repeat (8) @(negedge clk);

        for (int i = 0; i < 16; i++) access(0, 32'h8000_0000 | 32'(i << 2), 32'h0, 2'b10, 0, 0, acc);
        for (int i = 0; i < 16; i++) access(0, 32'h8040_0000 | 32'(i << 2), 32'h0, 2'b10, 0, 0, acc);
        req = 0;
        drain();
        chk("uart_tx_leftover", uart_txq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
